// File: rtl/wb_mul_feeder_pkg.sv
// Shared register map, bit positions and sequencer states for the Wishbone
// multiplier feeder.
package wb_mul_feeder_pkg;

  localparam logic [1:0] REG_OPND   = 2'd0;
  localparam logic [1:0] REG_RESULT = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_OP_FULL     = 0;
  localparam int unsigned ST_OP_EMPTY    = 1;
  localparam int unsigned ST_RES_FULL    = 2;
  localparam int unsigned ST_RES_EMPTY   = 3;
  localparam int unsigned ST_BUSY        = 4;
  localparam int unsigned ST_OVF         = 5;
  localparam int unsigned ST_UNF         = 6;
  localparam int unsigned ST_OP_CNT_LSB  = 8;
  localparam int unsigned ST_RES_CNT_LSB = 12;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_e;

endpackage

// File: rtl/wb_mul_feeder_sync_fifo.sv
// Single-clock FIFO with flush; a push on a full FIFO is accepted when a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_dout_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full_c  = (r_count == CW'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_dout_c  = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  assign w_do_pop  = i_pop & ~o_empty_c & ~i_flush;
  assign w_do_push = i_push & (~o_full_c | w_do_pop) & ~i_flush;

  // Storage carries no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_mul_feeder.sv
// Wishbone slave that queues operand pairs, sequences them through the r8_mb8
// multiplier one at a time and queues the products for firmware to read.
module wb_mul_feeder
  import wb_mul_feeder_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned OP_W       = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic [OP_W-1:0]   mx_o,
  output logic [OP_W-1:0]   my_o,
  output logic              mul_rst_o,
  input  logic [2*OP_W-1:0] product_i,
  output logic              irq_o
);

  localparam int unsigned PW    = 2 * OP_W;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(MUL_LAT) + 1;

  logic             r_ack;
  logic [31:0]      r_dat;
  logic             r_enable;
  logic             r_irq_en;
  logic             r_ovf;
  logic             r_unf;
  logic             r_irq;
  logic             r_mul_rst;
  logic [OP_W-1:0]  r_mx;
  logic [OP_W-1:0]  r_my;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_issue;
  logic             w_capt;

  logic             w_sel;
  logic             w_req;
  logic             w_wr;
  logic             w_rd;
  logic [1:0]       w_idx;
  logic             w_clear;
  logic             w_op_push;
  logic             w_res_pop;
  logic             w_res_rd_empty;
  logic [31:0]      w_status;
  logic [31:0]      w_rdata;

  logic [PW-1:0]    w_op_dout;
  logic             w_op_full;
  logic             w_op_empty;
  logic [FCW-1:0]   w_op_count;
  logic [PW-1:0]    w_res_dout;
  logic             w_res_full;
  logic             w_res_empty;
  logic [FCW-1:0]   w_res_count;

  logic             w_unused;

  assign w_unused = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:PW]};

  // Bus decode: one access is taken per request; the ack cycle blocks a repeat.
  assign w_sel   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_req   = w_sel & ~r_ack;
  assign w_wr    = w_req & wbs_we_i;
  assign w_rd    = w_req & ~wbs_we_i;
  assign w_idx   = wbs_adr_i[3:2];

  assign w_clear        = w_wr & (w_idx == REG_CTRL) & wbs_dat_i[CTRL_CLEAR];
  assign w_op_push      = w_wr & (w_idx == REG_OPND) & (wbs_sel_i[1:0] == 2'b11);
  assign w_res_rd_empty = w_rd & (w_idx == REG_RESULT) & w_res_empty;
  assign w_res_pop      = w_rd & (w_idx == REG_RESULT) & ~w_res_empty;

  sync_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_op_fifo (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_ni),
    .i_push    (w_op_push),
    .i_pop     (w_issue),
    .i_flush   (w_clear),
    .i_din     (wbs_dat_i[PW-1:0]),
    .o_dout_c  (w_op_dout),
    .o_full_c  (w_op_full),
    .o_empty_c (w_op_empty),
    .o_count   (w_op_count)
  );

  sync_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_ni),
    .i_push    (w_capt),
    .i_pop     (w_res_pop),
    .i_flush   (w_clear),
    .i_din     (product_i),
    .o_dout_c  (w_res_dout),
    .o_full_c  (w_res_full),
    .o_empty_c (w_res_empty),
    .o_count   (w_res_count)
  );

  // Sequencer next-state: one operation in flight, clear aborts it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_capt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_enable && !w_op_empty && !w_res_full) begin
          w_issue     = 1'b1;
          w_cnt_nxt   = CNT_W'(MUL_LAT - 1);
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = CAPT;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_clear) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_issue     = 1'b0;
      w_capt      = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_status                        = '0;
    w_status[ST_OP_FULL]            = w_op_full;
    w_status[ST_OP_EMPTY]           = w_op_empty;
    w_status[ST_RES_FULL]           = w_res_full;
    w_status[ST_RES_EMPTY]          = w_res_empty;
    w_status[ST_BUSY]               = (r_state != IDLE);
    w_status[ST_OVF]                = r_ovf;
    w_status[ST_UNF]                = r_unf;
    w_status[ST_OP_CNT_LSB +: 4]    = 4'(w_op_count);
    w_status[ST_RES_CNT_LSB +: 4]   = 4'(w_res_count);
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_RESULT: w_rdata = w_res_empty ? 32'h0 : 32'(w_res_dout);
      REG_STATUS: w_rdata = w_status;
      REG_CTRL: begin
        w_rdata[CTRL_ENABLE] = r_enable;
        w_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_sel & ~r_ack;
      r_dat <= w_rd ? w_rdata : 32'h0;
    end
  end

  // Control register and sticky error flags; set has priority over write-1-to-clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr && (w_idx == REG_CTRL)) begin
        r_enable <= wbs_dat_i[CTRL_ENABLE];
        r_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      if (w_clear) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        if (w_op_push && w_op_full && !w_issue)                  r_ovf <= 1'b1;
        else if (w_wr && (w_idx == REG_STATUS) && wbs_dat_i[ST_OVF]) r_ovf <= 1'b0;
        if (w_res_rd_empty)                                      r_unf <= 1'b1;
        else if (w_wr && (w_idx == REG_STATUS) && wbs_dat_i[ST_UNF]) r_unf <= 1'b0;
      end
    end
  end

  // Multiplier drive, its reset pulse and the interrupt.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_mx      <= '0;
      r_my      <= '0;
      r_mul_rst <= 1'b1;
      r_irq     <= 1'b0;
    end else begin
      if (w_issue) begin
        r_mx <= w_op_dout[OP_W-1:0];
        r_my <= w_op_dout[PW-1:OP_W];
      end
      r_mul_rst <= w_clear;
      r_irq     <= r_irq_en & ~w_res_empty;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign mx_o      = r_mx;
  assign my_o      = r_my;
  assign mul_rst_o = r_mul_rst;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_mul_feeder.sv
// Directed bench for wb_mul_feeder with a latency-accurate multiplier model.
module tb_wb_mul_feeder;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int unsigned MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic [7:0]  mx, my;
  logic        mul_rst;
  logic [15:0] product;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pipe [MUL_LAT];

  always #5 clk = ~clk;

  // Product becomes valid MUL_LAT clocks after the operands change.
  always @(posedge clk) begin
    pipe[0] <= {8'h00, mx} * {8'h00, my};
    for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign product = pipe[MUL_LAT-1];

  wb_mul_feeder #(.BASE_ADR(BASE), .FIFO_DEPTH(4), .MUL_LAT(MUL_LAT), .OP_W(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_r),
    .mx_o      (mx),
    .my_o      (my),
    .mul_rst_o (mul_rst),
    .product_i (product),
    .irq_o     (irq)
  );

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL wr_ack adr=%h observed=no-ack expected=ack", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    got = 1'b0;
    d = 32'hDEAD_BEEF;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_r; end
    end
    cyc = 1'b0; stb = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin
      n_err++;
      $display("FAIL rd_ack adr=%h observed=no-ack expected=ack", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
    #22;
    n_cmp++; if (mul_rst !== 1'b1) begin n_err++; $display("FAIL rst_mul_rst observed=%b expected=1", mul_rst); end
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_ack observed=%b expected=0", ack); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq observed=%b expected=0", irq); end
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    n_cmp++; if (mul_rst !== 1'b1) begin n_err++; $display("FAIL rel_mul_rst observed=%b expected=1", mul_rst); end
    @(posedge clk); #1;
    n_cmp++; if (mul_rst !== 1'b0) begin n_err++; $display("FAIL edge_mul_rst observed=%b expected=0", mul_rst); end
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL rst_status observed=%h expected=0000000a", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    wb_write(BASE + 32'hC, 32'h5, 4'hF);
    wb_write(BASE + 32'h0, 32'h0A0C, 4'hF);
    for (int i = 0; i <= MUL_LAT; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (mx !== 8'h0C || my !== 8'h0A) begin
        n_err++; $display("FAIL hold_ops cyc=%0d observed=%h/%h expected=0c/0a", i, mx, my);
      end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early cyc=%0d observed=%b expected=0", i, irq); end
    end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_capt observed=%b expected=0", irq); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_assert observed=%b expected=1", irq); end
    wb_read(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h0000_0078) begin n_err++; $display("FAIL result_78 observed=%h expected=00000078", d); end
    @(posedge clk); #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_deassert observed=%b expected=0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [31:0] exp_res [4];
    exp_res[0] = 32'd2; exp_res[1] = 32'd12; exp_res[2] = 32'd30; exp_res[3] = 32'd56;
    wb_write(BASE + 32'hC, 32'h0, 4'hF);
    wb_write(BASE + 32'h0, 32'h0909, 4'h1);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL sel_ignored observed=%h expected=0000000a", d); end
    wb_write(BASE + 32'h0, 32'h0201, 4'hF);
    wb_write(BASE + 32'h0, 32'h0403, 4'hF);
    wb_write(BASE + 32'h0, 32'h0605, 4'hF);
    wb_write(BASE + 32'h0, 32'h0807, 4'hF);
    wb_write(BASE + 32'h0, 32'h0909, 4'hF);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_0429) begin n_err++; $display("FAIL full_ovf observed=%h expected=00000429", d); end
    wb_write(BASE + 32'hC, 32'h1, 4'hF);
    repeat (40) @(posedge clk);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_4026) begin n_err++; $display("FAIL res_full observed=%h expected=00004026", d); end
    for (int i = 0; i < 4; i++) begin
      wb_read(BASE + 32'h4, d);
      n_cmp++;
      if (d !== exp_res[i]) begin n_err++; $display("FAIL order[%0d] observed=%h expected=%h", i, d, exp_res[i]); end
    end
    wb_write(BASE + 32'h8, 32'h20, 4'hF);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL ovf_clear observed=%h expected=0000000a", d); end
  endtask

  task automatic test_underflow();
    logic [31:0] d;
    wb_read(BASE + 32'h4, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unf_data observed=%h expected=00000000", d); end
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_004A) begin n_err++; $display("FAIL unf_set observed=%h expected=0000004a", d); end
    wb_write(BASE + 32'h8, 32'h40, 4'hF);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL unf_clear observed=%h expected=0000000a", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    wb_write(BASE + 32'h0, 32'h0303, 4'hF);
    repeat (2) @(posedge clk);
    wb_write(BASE + 32'hC, 32'h3, 4'hF);
    n_cmp++; if (mul_rst !== 1'b1) begin n_err++; $display("FAIL clr_pulse observed=%b expected=1", mul_rst); end
    @(posedge clk); #1;
    n_cmp++; if (mul_rst !== 1'b0) begin n_err++; $display("FAIL clr_pulse_end observed=%b expected=0", mul_rst); end
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL clr_idle observed=%h expected=0000000a", d); end
    repeat (10) @(posedge clk);
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL clr_no_result observed=%h expected=0000000a", d); end
    wb_read(BASE + 32'hC, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_err++; $display("FAIL ctrl_read observed=%h expected=00000001", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        seen;
    wb_write(BASE + 32'hC, 32'h5, 4'hF);
    wb_write(BASE + 32'h0, 32'h0505, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mx !== 8'h05 || my !== 8'h05) begin n_err++; $display("FAIL pre_rst_ops observed=%h/%h expected=05/05", mx, my); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mx !== 8'h0 || my !== 8'h0 || mul_rst !== 1'b1 || irq !== 1'b0 || ack !== 1'b0 || dat_r !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst observed=mx%h my%h mr%b irq%b ack%b dat%h expected=mx00 my00 mr1 irq0 ack0 dat0",
               mx, my, mul_rst, irq, ack, dat_r);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) seen = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL oob_ack observed=%b expected=0", seen); end
    wb_read(BASE + 32'h8, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_err++; $display("FAIL post_rst_status observed=%h expected=0000000a", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_underflow();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
